// File: rtl/pwm_sequencer_if.sv
// pwm_sequencer_if: configuration inputs and driven outputs of the PWM sequencer.
interface pwm_sequencer_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;
    logic        active;
    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        input  out, period_start, active
    );
    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        output out, period_start, active
    );
endinterface

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: 16 static/PWM outputs from SPI config, shared duty, idle/run counter control.
// Optional PWM_SHADOW_UPDATE_EN: PWM config is latched only at period start / RUN entry.
module pwm_sequencer #(
    parameter int PRESCALE = 13
) (
    input logic            clk,
    input logic            rst_n,
    pwm_sequencer_if.slave bus
);
    localparam int PW = $clog2(PRESCALE + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pre_cnt, w_pre_nxt;
    logic [7:0]    r_pwm_cnt, w_pwm_nxt;
    logic [15:0]   r_out, w_out_nxt;
    logic          r_period_start;
    logic [15:0]   w_en_out, w_en_pwm, w_pwm_mask, w_static;
    logic [7:0]    w_duty;
    logic          w_any, w_tick, w_wrap, w_enter, w_start, w_pwm_sig;

    assign w_en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign w_en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    assign w_any    = |(w_en_out & w_en_pwm);
    assign w_static = w_en_out & ~w_en_pwm;
    assign w_tick   = (r_state == RUN) && (r_pre_cnt == PW'(PRESCALE - 1));
    assign w_wrap   = w_tick && (r_pwm_cnt == 8'hFF);
    assign w_enter  = (r_state == IDLE) && w_any;
    assign w_start  = w_enter | w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Output is computed from next-cycle counter values so out aligns with the counters.
    always_comb begin
        w_state_nxt = w_enter ? RUN : (w_wrap && !w_any) ? IDLE : r_state;
        w_pre_nxt   = (r_state == IDLE || w_tick) ? '0 : r_pre_cnt + PW'(1);
        w_pwm_nxt   = (r_state == IDLE) ? 8'd0 : r_pwm_cnt + {7'd0, w_tick};
        w_pwm_sig   = (w_state_nxt == RUN) && (w_duty == 8'hFF || w_pwm_nxt < w_duty);
        w_out_nxt   = w_static | (w_pwm_mask & {16{w_pwm_sig}});
    end

`ifdef PWM_SHADOW_UPDATE_EN
    logic [7:0]  r_sh_duty;
    logic [15:0] r_sh_en_out, r_sh_en_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_duty   <= '0;
            r_sh_en_out <= '0;
            r_sh_en_pwm <= '0;
        end else if (w_start) begin
            r_sh_duty   <= bus.pwm_duty_cycle;
            r_sh_en_out <= w_en_out;
            r_sh_en_pwm <= w_en_pwm;
        end
    end

    // A wrap and a config write in the same cycle: the new value governs the new period.
    assign w_duty     = w_start ? bus.pwm_duty_cycle : r_sh_duty;
    assign w_pwm_mask = w_start ? (w_en_out & w_en_pwm) : (r_sh_en_out & r_sh_en_pwm);
`else
    assign w_duty     = bus.pwm_duty_cycle;
    assign w_pwm_mask = w_en_out & w_en_pwm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pre_cnt      <= w_pre_nxt;
            r_pwm_cnt      <= w_pwm_nxt;
            r_out          <= w_out_nxt;
            r_period_start <= w_start;
        end
    end

    assign bus.out          = r_out;
    assign bus.period_start = r_period_start;
    assign bus.active       = (r_state == RUN);
endmodule

// File: tb/tb_pwm_sequencer.sv
// tb_pwm_sequencer: scoreboard bench; a period-position model predicts every output cycle.
module tb_pwm_sequencer;
    localparam int P   = 13;
    localparam int PER = 256 * P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [17:0] q[$];

    pwm_sequencer_if bus();
    pwm_sequencer #(.PRESCALE(P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        @(posedge clk);
        #1;
        {bus.en_reg_out_15_8, bus.en_reg_out_7_0} = eo;
        {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0} = ep;
        bus.pwm_duty_cycle = d;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Model: position t within the 256*P-cycle period while running.
    initial begin
        bit run = 1'b0;
        int t = 0;
        logic [15:0] eo, ep, e_out;
        logic ps, hi;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                run = 1'b0;
                t = 0;
            end else begin
                eo = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
                ep = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
                ps = 1'b0;
                if (!run) begin
                    if (|(eo & ep)) begin
                        run = 1'b1;
                        t = 0;
                        ps = 1'b1;
                    end
                end else if (t + 1 == PER) begin
                    t = 0;
                    ps = 1'b1;
                    run = |(eo & ep);
                end else begin
                    t++;
                end
                hi = run && (bus.pwm_duty_cycle == 8'hFF || (t / P) < int'(bus.pwm_duty_cycle));
                e_out = (eo & ~ep) | ((eo & ep) & {16{hi}});
                q.push_back({e_out, ps, run});
            end
        end
    end

    // Monitor: compares one predicted output word per cycle.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                chk("reset_outputs", {14'd0, bus.out, bus.period_start, bus.active}, 32'd0);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                chk("scoreboard", {14'd0, bus.out, bus.period_start, bus.active}, {14'd0, e});
            end
        end
    end

    initial begin
        int hi, pc, w;
        logic [15:0] eo, ep;
        logic [7:0]  d;
        bus.en_reg_out_7_0  = '0;
        bus.en_reg_out_15_8 = '0;
        bus.en_reg_pwm_7_0  = '0;
        bus.en_reg_pwm_15_8 = '0;
        bus.pwm_duty_cycle  = '0;
        #23 rst_n = 1'b1;
        cyc(10000);
        set_cfg(16'h0001, 16'h0000, 8'h80);
        cyc(20);
        chk("static_out0", {16'd0, bus.out}, 32'h0001);
        chk("static_idle", {31'd0, bus.active}, 32'd0);
        set_cfg(16'h8001, 16'h8001, 8'h80);
        cyc(PER + 100);
        w = 0;
        while (!bus.period_start && w < PER + 10) begin
            @(negedge clk);
            w++;
        end
        chk("wait_period_start", {31'd0, bus.period_start}, 32'd1);
        hi = bus.out[0];
        pc = 1;
        repeat (PER - 1) begin
            @(negedge clk);
            hi += int'(bus.out[0]);
            pc += int'(bus.period_start);
        end
        chk("duty80_high_cycles", hi, 1664);
        chk("duty80_ps_per_period", pc, 1);
        set_cfg(16'h0008, 16'h0008, 8'h00);
        cyc(3 * PER);
        set_cfg(16'h0008, 16'h0008, 8'hFF);
        cyc(3 * PER);
        set_cfg(16'h0008, 16'h0008, 8'h40);
        cyc(PER / 2);
        set_cfg(16'h0008, 16'h0008, 8'hC0);
        cyc(PER + 50);
        set_cfg(16'h0008, 16'h0000, 8'hC0);
        cyc(5);
        chk("active_after_clear", {31'd0, bus.active}, 32'd1);
        cyc(PER);
        chk("idle_after_wrap", {31'd0, bus.active}, 32'd0);
        set_cfg(16'h0001, 16'h0001, 8'hFF);
        cyc(700);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_out", {16'd0, bus.out}, 32'd0);
        chk("async_reset_active", {31'd0, bus.active}, 32'd0);
        cyc(3);
        #2 rst_n = 1'b1;
        cyc(500);
        for (int i = 0; i < 15; i++) begin
            eo = 16'($urandom);
            ep = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            case ($urandom_range(0, 3))
                0: d = 8'h00;
                1: d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            set_cfg(eo, ep, d);
            cyc($urandom_range(50, 1500));
        end
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
